sar_adc_multich: RTL and testbench
==================================

Name: sar_adc_multich

Overview:
- Parametrised successor to the single-channel SAR ADC core.
- Converts one of CH digital-modelled analog inputs (single mode), or sweeps all CH inputs in order (scan mode).
- Optional 2^AVG_LOG2 oversample averaging per channel.
- Sits between the sample front-end model and the downstream result consumer; the result path is a one-cycle valid-qualified stream tagged with the channel index.

Parameters:
- N, 10, resolution in bits (bits per sample and per result).
- CH, 4, number of input channels (>=1).
- AVG_LOG2, 0, log2 of conversions averaged per channel (0 = no averaging).
- TW, 16, width of conv_time counter.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- start  in  1  conversion request; accepted only when busy=0.
- mode  in  1  0 = single channel, 1 = scan channels 0..CH-1; latched at accept.
- ch_sel  in  max(1,$clog2(CH))  channel for single mode; latched at accept.
- vin  in  CH*N  flattened channel inputs, channel k = vin[k*N +: N].
- dout  out  N  latest result (averaged code).
- dout_ch  out  max(1,$clog2(CH))  channel index of dout.
- dout_valid  out  1  one-cycle pulse when dout/dout_ch update.
- eoc  out  1  one-cycle pulse, end of the whole request (after last channel).
- busy  out  1  high from accept until request complete.
- conv_time  out  TW  number of cycles busy was high for the last request.

Behaviour:
- Reset: state IDLE; dout, dout_ch, dout_valid, eoc, busy, conv_time, internal sum/counters = 0. Reset mid-conversion aborts immediately; no dout_valid or eoc is issued.
- Accept: in IDLE with start=1 at a clock edge: latch mode and ch_sel (ch_sel >= CH clamps to CH-1); busy=1 from that edge. In scan mode the channel starts at 0. start while busy is ignored; no queuing.
- FSM states: IDLE -> SAMPLE -> CONVERT -> (SAMPLE | DONE) -> (SAMPLE | IDLE).
- SAMPLE (1 cycle): capture the current channel's vin slice into the sample register; clear trial code; bit pointer = N-1.
- CONVERT (N cycles, MSB first):
  - trial = code | (1<<bit).
  - If sample >= trial, keep the bit; otherwise clear it.
  - Decrement the bit pointer each cycle.
- After bit 0: add the code into the sum register (N+AVG_LOG2 bits).
  - If passes done < 2^AVG_LOG2, return to SAMPLE. vin is resampled each pass, so input changes between passes are averaged.
  - Otherwise go to DONE.
- DONE (1 cycle):
  - dout = sum >> AVG_LOG2 (truncating); dout_ch = channel; dout_valid=1 for this cycle only.
  - Clear sum and pass counter.
  - If scan mode and channel < CH-1: increment channel and go to SAMPLE.
  - Otherwise assert eoc=1 (same cycle as the final dout_valid) and go to IDLE. busy falls at the edge ending DONE; conv_time loads at the same edge.
- Per-channel latency: 2^AVG_LOG2*(N+1)+1 cycles. Request latency: that figure for single mode; CH times it for scan mode.
- conv_time: counts busy-high cycles and saturates at 2^TW-1; holds its value until the next request completes.
- For a constant input, dout equals the channel's vin exactly, for any AVG_LOG2.
- dout/dout_ch hold between updates.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Defaults (N=10, CH=4, AVG_LOG2=0); ch0=1000, single ch_sel=0 -> dout=1000, dout_ch=0, dout_valid and eoc coincide, busy high 12 cycles, conv_time=12.
- Scan mode, ch0..3 = 1000, 674, 336, 0 -> four dout_valid pulses 12 cycles apart: (0,1000), (1,674), (2,336), (3,0); eoc only with the 4th; conv_time=48.
- AVG_LOG2=2, constant ch2=513 -> dout=513 after 45 cycles. Input alternates 512/515 between passes (samples 512, 515, 512, 515) -> sum 2054, dout=513.
- Boundaries:
  - vin=0 -> dout=0; vin=1023 -> dout=1023.
  - start pulsed again mid-conversion -> ignored, single eoc.
  - start held high -> back-to-back requests with one IDLE cycle between.
- reset asserted mid-scan (during ch1) -> all outputs 0 asynchronously, no eoc. A new start afterwards converts correctly.
- CH=3 instance, ch_sel=3 -> clamped: dout_ch=2, dout = ch2 input.
- Random vin for 20 single conversions -> dout==vin every time; conv_time=12.

Source files
------------

// File: rtl/sar_adc_multich.sv
// Multi-channel SAR ADC controller: single or scan request, optional 2^AVG_LOG2 averaging.
// Results leave as a one-cycle valid pulse tagged with the channel index.
//
// state   | meaning
// IDLE    | waiting for start, busy low
// SAMPLE  | capture the current channel input, arm the bit pointer at MSB
// CONVERT | one successive-approximation trial per cycle, MSB first
// DONE    | result/valid (and eoc on the last channel) visible, advance or finish
module sar_adc_multich #(
  parameter int N        = 10,
  parameter int CH       = 4,
  parameter int AVG_LOG2 = 0,
  parameter int TW       = 16,
  parameter int CHW      = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic            mode_i,
  input  logic [CHW-1:0]  ch_sel_i,
  input  logic [CH*N-1:0] vin_i,
  output logic [N-1:0]    dout_o,
  output logic [CHW-1:0]  dout_ch_o,
  output logic            dout_valid_o,
  output logic            eoc_o,
  output logic            busy_o,
  output logic [TW-1:0]   conv_time_o
);

  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = N + AVG_LOG2;
  localparam int PW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [PW-1:0]  PASS_LAST = PW'((1 << AVG_LOG2) - 1);
  localparam logic [CHW-1:0] CH_LAST   = CHW'(CH - 1);
  localparam logic [TW-1:0]  CT_MAX    = {TW{1'b1}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAMPLE  = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t         state_q;
  logic           scan_q;
  logic [CHW-1:0] ch_q;
  logic [N-1:0]   sample_q;
  logic [N-1:0]   code_q;
  logic [BW-1:0]  bit_q;
  logic [SW-1:0]  sum_q;
  logic [PW-1:0]  pass_q;
  logic [TW-1:0]  cnt_q;
  logic [N-1:0]   dout_q;
  logic [CHW-1:0] dout_ch_q;
  logic           dout_valid_q;
  logic           eoc_q;
  logic           busy_q;
  logic [TW-1:0]  conv_time_q;

  logic [N-1:0]   vin_ch;
  logic [N-1:0]   bit_mask;
  logic [N-1:0]   trial;
  logic [N-1:0]   code_d;
  logic [SW-1:0]  sum_d;
  logic [TW-1:0]  cnt_d;
  logic [CHW-1:0] ch_start;
  logic           more_ch;

  always_comb begin
    vin_ch = '0;
    for (int k = 0; k < CH; k++) begin
      if (ch_q == CHW'(k)) vin_ch = vin_i[k*N +: N];
    end
    bit_mask = N'(1) << bit_q;
    trial    = code_q | bit_mask;
    code_d   = (sample_q >= trial) ? trial : code_q;
    sum_d    = sum_q + SW'(code_d);
    cnt_d    = (cnt_q == CT_MAX) ? cnt_q : cnt_q + TW'(1);
    // Out-of-range single-mode channels fold onto the highest channel.
    if (mode_i)                  ch_start = '0;
    else if (ch_sel_i > CH_LAST) ch_start = CH_LAST;
    else                         ch_start = ch_sel_i;
    more_ch  = scan_q && (ch_q != CH_LAST);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      scan_q       <= 1'b0;
      ch_q         <= '0;
      sample_q     <= '0;
      code_q       <= '0;
      bit_q        <= '0;
      sum_q        <= '0;
      pass_q       <= '0;
      cnt_q        <= '0;
      dout_q       <= '0;
      dout_ch_q    <= '0;
      dout_valid_q <= 1'b0;
      eoc_q        <= 1'b0;
      busy_q       <= 1'b0;
      conv_time_q  <= '0;
    end else begin
      dout_valid_q <= 1'b0;
      eoc_q        <= 1'b0;
      if (busy_q) cnt_q <= cnt_d;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= SAMPLE;
            busy_q  <= 1'b1;
            scan_q  <= mode_i;
            ch_q    <= ch_start;
            cnt_q   <= TW'(1);
            sum_q   <= '0;
            pass_q  <= PASS_LAST;
          end
        end
        SAMPLE: begin
          sample_q <= vin_ch;
          code_q   <= '0;
          bit_q    <= BW'(N - 1);
          state_q  <= CONVERT;
        end
        CONVERT: begin
          code_q <= code_d;
          if (bit_q != '0) begin
            bit_q <= bit_q - BW'(1);
          end else begin
            sum_q <= sum_d;
            if (pass_q != '0) begin
              pass_q  <= pass_q - PW'(1);
              state_q <= SAMPLE;
            end else begin
              // Result registers load here so they are visible during DONE.
              state_q      <= DONE;
              dout_q       <= sum_d[SW-1:AVG_LOG2];
              dout_ch_q    <= ch_q;
              dout_valid_q <= 1'b1;
              eoc_q        <= !more_ch;
            end
          end
        end
        DONE: begin
          sum_q  <= '0;
          pass_q <= PASS_LAST;
          if (more_ch) begin
            ch_q    <= ch_q + CHW'(1);
            state_q <= SAMPLE;
          end else begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            conv_time_q <= cnt_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dout_o       = dout_q;
  assign dout_ch_o    = dout_ch_q;
  assign dout_valid_o = dout_valid_q;
  assign eoc_o        = eoc_q;
  assign busy_o       = busy_q;
  assign conv_time_o  = conv_time_q;

endmodule

// File: tb/tb_sar_adc_multich.sv
// Bench for sar_adc_multich: cycle model for the default instance plus directed
// literal checks on default, averaging (AVG_LOG2=2) and three-channel instances.
module tb_sar_adc_multich;
  localparam int N   = 10;
  localparam int CH  = 4;
  localparam int PER = N + 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic            start0 = 1'b0, mode0 = 1'b0;
  logic [1:0]      chsel0 = '0;
  logic [CH*N-1:0] vin0 = '0;
  logic [N-1:0]    dout0;
  logic [1:0]      dch0;
  logic            dv0, eoc0, busy0;
  logic [15:0]     ct0;

  logic            startA = 1'b0, modeA = 1'b0;
  logic [1:0]      chselA = '0;
  logic [CH*N-1:0] vinA = '0;
  logic [N-1:0]    doutA;
  logic [1:0]      dchA;
  logic            dvA, eocA, busyA;
  logic [15:0]     ctA;

  logic            start3 = 1'b0, mode3 = 1'b0;
  logic [1:0]      chsel3 = '0;
  logic [3*N-1:0]  vin3 = '0;
  logic [N-1:0]    dout3;
  logic [1:0]      dch3;
  logic            dv3, eoc3, busy3;
  logic [15:0]     ct3;

  sar_adc_multich #(.N(10), .CH(4), .AVG_LOG2(0), .TW(16)) u0 (
    .clk_i(clk), .reset_i(rst), .start_i(start0), .mode_i(mode0), .ch_sel_i(chsel0),
    .vin_i(vin0), .dout_o(dout0), .dout_ch_o(dch0), .dout_valid_o(dv0), .eoc_o(eoc0),
    .busy_o(busy0), .conv_time_o(ct0));

  sar_adc_multich #(.N(10), .CH(4), .AVG_LOG2(2), .TW(16)) u_avg (
    .clk_i(clk), .reset_i(rst), .start_i(startA), .mode_i(modeA), .ch_sel_i(chselA),
    .vin_i(vinA), .dout_o(doutA), .dout_ch_o(dchA), .dout_valid_o(dvA), .eoc_o(eocA),
    .busy_o(busyA), .conv_time_o(ctA));

  sar_adc_multich #(.N(10), .CH(3), .AVG_LOG2(0), .TW(16)) u_ch3 (
    .clk_i(clk), .reset_i(rst), .start_i(start3), .mode_i(mode3), .ch_sel_i(chsel3),
    .vin_i(vin3), .dout_o(dout3), .dout_ch_o(dch3), .dout_valid_o(dv3), .eoc_o(eoc3),
    .busy_o(busy3), .conv_time_o(ct3));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model of the default instance: a request spans PER cycles per channel,
  // each channel's result appears on the last of its PER cycles.
  int m_busy = 0, m_cyc = 0, m_nch = 0, m_first = 0;
  int m_valid = 0, m_eoc = 0, m_dout = 0, m_ch = 0, m_ct = 0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_busy = 0; m_cyc = 0; m_nch = 0; m_first = 0;
      m_valid = 0; m_eoc = 0; m_dout = 0; m_ch = 0; m_ct = 0;
    end else begin
      m_valid = 0;
      m_eoc   = 0;
      if (m_busy == 0) begin
        if (start0) begin
          m_busy  = 1;
          m_cyc   = 1;
          m_nch   = mode0 ? CH : 1;
          m_first = mode0 ? 0 : ((int'(chsel0) > CH - 1) ? CH - 1 : int'(chsel0));
        end
      end else if (m_cyc == PER * m_nch) begin
        m_busy = 0;
        m_ct   = m_cyc;
      end else begin
        m_cyc++;
      end
      if (m_busy != 0 && (m_cyc % PER) == 0) begin
        m_ch    = m_first + m_cyc / PER - 1;
        m_dout  = int'(vin0[m_ch*N +: N]);
        m_valid = 1;
        m_eoc   = (m_cyc == PER * m_nch) ? 1 : 0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("busy",       int'(busy0), m_busy);
    chk("dout_valid", int'(dv0),   m_valid);
    chk("eoc",        int'(eoc0),  m_eoc);
    chk("dout",       int'(dout0), m_dout);
    chk("dout_ch",    int'(dch0),  m_ch);
    chk("conv_time",  int'(ct0),   m_ct);
  end

  int q_cyc[$];
  int q_ch[$];
  int q_dout[$];

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic set_start(input int which, input logic v);
    case (which)
      0: start0 = v;
      1: startA = v;
      default: start3 = v;
    endcase
  endtask

  function automatic logic get_dv(input int which);
    return (which == 0) ? dv0 : (which == 1) ? dvA : dv3;
  endfunction

  function automatic logic get_eoc(input int which);
    return (which == 0) ? eoc0 : (which == 1) ? eocA : eoc3;
  endfunction

  function automatic int get_dout(input int which);
    return (which == 0) ? int'(dout0) : (which == 1) ? int'(doutA) : int'(dout3);
  endfunction

  function automatic int get_ch(input int which);
    return (which == 0) ? int'(dch0) : (which == 1) ? int'(dchA) : int'(dch3);
  endfunction

  // Raises start and counts busy cycles (1 = first busy cycle) until eoc.
  task automatic run_req(input int which, input bit hold, input int restart_at,
                         input bit alt, output int lat);
    int  n;
    bit  seen;
    q_cyc.delete(); q_ch.delete(); q_dout.delete();
    @(negedge clk);
    set_start(which, 1'b1);
    n = 0;
    seen = 0;
    while (!seen && n < 400) begin
      @(negedge clk);
      n++;
      if (n == restart_at) set_start(which, 1'b1);
      else if (!hold) set_start(which, 1'b0);
      if (alt) begin
        if (n == 6)  vinA[2*N +: N] = 10'd515;
        if (n == 17) vinA[2*N +: N] = 10'd512;
        if (n == 28) vinA[2*N +: N] = 10'd515;
      end
      if (get_dv(which)) begin
        q_cyc.push_back(n);
        q_ch.push_back(get_ch(which));
        q_dout.push_back(get_dout(which));
      end
      if (get_eoc(which)) seen = 1;
    end
    if (!seen) chk("eoc_timeout", n, -1);
    lat = n;
  endtask

  int lat, cnt, gap;
  int rv_ch, rv_val;
  int exp_scan[4] = '{1000, 674, 336, 0};

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_dout", int'(dout0), 0);
    chk("rst_ct",   int'(ct0),   0);
    chk("rst_dv",   int'(dv0),   0);
    chk("rst_eoc",  int'(eoc0),  0);
    rst = 1'b0;

    vin0[0*N +: N] = 10'd1000;
    vin0[1*N +: N] = 10'd674;
    vin0[2*N +: N] = 10'd336;
    vin0[3*N +: N] = 10'd0;

    mode0 = 1'b0; chsel0 = 2'd0;
    run_req(0, 0, -1, 0, lat);
    chk("single_lat",    lat, 12);
    chk("single_nvalid", q_cyc.size(), 1);
    chk("single_vcyc",   qget(q_cyc, 0), 12);
    chk("single_dout",   qget(q_dout, 0), 1000);
    chk("single_ch",     qget(q_ch, 0), 0);
    @(negedge clk);
    chk("single_ct", int'(ct0), 12);
    chk("single_busy_after", int'(busy0), 0);

    mode0 = 1'b1;
    run_req(0, 0, -1, 0, lat);
    chk("scan_lat",    lat, 48);
    chk("scan_nvalid", q_cyc.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("scan_vcyc", qget(q_cyc, i), PER * (i + 1));
      chk("scan_ch",   qget(q_ch, i), i);
      chk("scan_dout", qget(q_dout, i), exp_scan[i]);
    end
    @(negedge clk);
    chk("scan_ct", int'(ct0), 48);

    mode0 = 1'b0; chsel0 = 2'd3;
    run_req(0, 0, -1, 0, lat);
    chk("zero_dout", qget(q_dout, 0), 0);
    vin0[1*N +: N] = 10'd1023; chsel0 = 2'd1;
    run_req(0, 0, -1, 0, lat);
    chk("full_dout", qget(q_dout, 0), 1023);
    chk("full_ch",   qget(q_ch, 0), 1);
    vin0[1*N +: N] = 10'd674;

    chsel0 = 2'd2;
    run_req(0, 0, 5, 0, lat);
    chk("restart_lat", lat, 12);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (eoc0) cnt++;
    end
    chk("restart_extra_eoc", cnt, 0);
    chk("restart_ct", int'(ct0), 12);

    chsel0 = 2'd0;
    run_req(0, 1, -1, 0, lat);
    chk("hold_lat1", lat, 12);
    gap = 0;
    @(negedge clk);
    while (!busy0 && gap < 20) begin
      gap++;
      @(negedge clk);
    end
    chk("hold_idle_gap", gap, 1);
    start0 = 1'b0;
    cnt = 1;
    while (!eoc0 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("hold_lat2", cnt, 12);

    mode0 = 1'b1;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    cnt = 1;
    while (cnt < PER + 4) begin
      @(negedge clk);
      cnt++;
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy",   int'(busy0), 0);
    chk("arst_dout",   int'(dout0), 0);
    chk("arst_ch",     int'(dch0),  0);
    chk("arst_dv",     int'(dv0),   0);
    chk("arst_ct",     int'(ct0),   0);
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (eoc0 || dv0) cnt++;
    end
    rst = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (eoc0 || dv0) cnt++;
    end
    chk("arst_no_result", cnt, 0);
    mode0 = 1'b0; chsel0 = 2'd1;
    run_req(0, 0, -1, 0, lat);
    chk("post_rst_dout", qget(q_dout, 0), 674);
    chk("post_rst_lat",  lat, 12);

    for (int i = 0; i < 20; i++) begin
      rv_ch  = int'($urandom_range(0, 3));
      rv_val = int'($urandom_range(0, 1023));
      vin0[rv_ch*N +: N] = N'(rv_val);
      chsel0 = 2'(rv_ch);
      run_req(0, 0, -1, 0, lat);
      chk("rand_dout", qget(q_dout, 0), rv_val);
      chk("rand_ch",   qget(q_ch, 0), rv_ch);
      @(negedge clk);
      chk("rand_ct", int'(ct0), 12);
    end

    modeA = 1'b0; chselA = 2'd2; vinA[2*N +: N] = 10'd513;
    run_req(1, 0, -1, 0, lat);
    chk("avg_const_lat",  lat, 45);
    chk("avg_const_dout", qget(q_dout, 0), 513);
    chk("avg_const_ch",   qget(q_ch, 0), 2);
    @(negedge clk);
    chk("avg_ct", int'(ctA), 45);
    vinA[2*N +: N] = 10'd512;
    run_req(1, 0, -1, 1, lat);
    chk("avg_alt_lat",  lat, 45);
    chk("avg_alt_dout", qget(q_dout, 0), 513);

    vin3[0*N +: N] = 10'd111;
    vin3[1*N +: N] = 10'd555;
    vin3[2*N +: N] = 10'd777;
    mode3 = 1'b0; chsel3 = 2'd3;
    run_req(2, 0, -1, 0, lat);
    chk("ch3_lat",  lat, 12);
    chk("ch3_ch",   qget(q_ch, 0), 2);
    chk("ch3_dout", qget(q_dout, 0), 777);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
